// File: rtl/uart_rx_fsm_ctrl.sv
// ============================================================================
// Module      : uart_rx_fsm_ctrl
// Description : UART receive frame controller (start/data/parity/stop FSM)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fsm_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic [PRESC_W-1:0]    edge_cnt,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  w_last;
    logic                  w_exp_par;

    assign w_last    = (edge_cnt_q == (prescale - PRESC_W'(1)));
    assign w_exp_par = par_typ_q ? ~^shreg_q : ^shreg_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;

        // Bit-period counter only runs inside a frame; wraps at the last edge.
        if (state_q == S_IDLE || w_last) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + PRESC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!RX_IN) begin
                    state_d   = S_START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (w_last) begin
                    state_d = sampled_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    shreg_d   = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    par_err_d = (sampled_bit != w_exp_par);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    stp_err_d = ~sampled_bit;
                    state_d   = S_IDLE;
                    // Only frames with a good stop bit and parity are delivered.
                    if (sampled_bit && !par_err_q) begin
                        p_data_d     = shreg_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign edge_cnt    = edge_cnt_q;
    assign busy        = (state_q != S_IDLE);
    assign dat_samp_en = (state_q != S_IDLE);
    assign P_DATA      = p_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fsm_ctrl.sv
// ============================================================================
// Module      : tb_uart_rx_fsm_ctrl
// Description : Directed self-checking bench for uart_rx_fsm_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fsm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic [5:0] edge_cnt;
    logic       dat_samp_en;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;
    int dv_cnt   = 0;
    int dv_base;
    logic [7:0] dv_log [0:63];

    always #5 clk = ~clk;

    uart_rx_fsm_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK         (clk),
        .RST         (rst),
        .RX_IN       (rx_in),
        .prescale    (prescale),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .dat_samp_en (dat_samp_en),
        .P_DATA      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    // Simple data_sampling stand-in: grab the line at mid-bit.
    always @(negedge clk) begin
        if (dat_samp_en && edge_cnt == (prescale >> 1))
            sampled_bit = rx_in;
    end

    always @(negedge clk) begin
        if (data_valid) begin
            if (dv_cnt < 64) dv_log[dv_cnt] = p_data;
            dv_cnt = dv_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (int'(prescale)) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
        drive_bit(1'b0);
        send_body(d, pe, pb, sb);
    endtask

    initial begin
        rst         = 1'b1;
        rx_in       = 1'b1;
        prescale    = 6'd8;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        sampled_bit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",   {31'd0, busy},       32'd0);
        check_eq("rst_pdata",  {24'd0, p_data},     32'd0);
        check_eq("rst_edge",   {26'd0, edge_cnt},   32'd0);
        check_eq("rst_dv",     {31'd0, data_valid}, 32'd0);
        check_eq("rst_samp",   {31'd0, dat_samp_en},32'd0);
        rst = 1'b0;
        idle(4);

        // 1: prescale 8, no parity, 0xA5
        dv_base = dv_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(12);
        check_eq("t1_dv_cnt",  dv_cnt - dv_base,    32'd1);
        check_eq("t1_dv_data", {24'd0, dv_log[0]},  32'h0A5);
        check_eq("t1_pdata",   {24'd0, p_data},     32'h0A5);
        check_eq("t1_par_err", {31'd0, par_err},    32'd0);
        check_eq("t1_stp_err", {31'd0, stp_err},    32'd0);
        check_eq("t1_busy",    {31'd0, busy},       32'd0);
        check_eq("t1_edge",    {26'd0, edge_cnt},   32'd0);

        // 2: prescale 16, even parity, 0x3C good then bad parity
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        dv_base = dv_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(20);
        check_eq("t2a_dv_cnt", dv_cnt - dv_base,    32'd1);
        check_eq("t2a_pdata",  {24'd0, p_data},     32'h03C);
        check_eq("t2a_par_err",{31'd0, par_err},    32'd0);
        dv_base = dv_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(20);
        check_eq("t2b_dv_cnt", dv_cnt - dv_base,    32'd0);
        check_eq("t2b_par_err",{31'd0, par_err},    32'd1);
        check_eq("t2b_stp_err",{31'd0, stp_err},    32'd0);
        check_eq("t2b_pdata",  {24'd0, p_data},     32'h03C);

        // 3: prescale 32, odd parity, 0x01 with low stop bit, then good frame
        prescale = 6'd32; par_typ = 1'b1;
        dv_base = dv_cnt;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        idle(36);
        check_eq("t3_dv_cnt",  dv_cnt - dv_base,    32'd0);
        check_eq("t3_stp_err", {31'd0, stp_err},    32'd1);
        check_eq("t3_par_err", {31'd0, par_err},    32'd0);
        drive_bit(1'b0);
        check_eq("t3_clr_busy",{31'd0, busy},       32'd1);
        check_eq("t3_clr_stp", {31'd0, stp_err},    32'd0);
        send_body(8'h01, 1'b1, 1'b0, 1'b1);
        idle(36);
        check_eq("t3_good_dv", dv_cnt - dv_base,    32'd1);
        check_eq("t3_good_pd", {24'd0, p_data},     32'h001);

        // 4: two-cycle glitch at prescale 8
        prescale = 6'd8; par_en = 1'b0;
        dv_base = dv_cnt;
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("t4_edge7",   {26'd0, edge_cnt},   32'd7);
        check_eq("t4_busy_in", {31'd0, busy},       32'd1);
        @(posedge clk); #1;
        check_eq("t4_abort",   {31'd0, busy},       32'd0);
        check_eq("t4_edge0",   {26'd0, edge_cnt},   32'd0);
        idle(4);
        check_eq("t4_dv_cnt",  dv_cnt - dv_base,    32'd0);
        check_eq("t4_flags",   {30'd0, par_err, stp_err}, 32'd0);

        // 5: back-to-back 0x55 then 0xFF at prescale 16
        prescale = 6'd16;
        dv_base = dv_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle(20);
        check_eq("t5_dv_cnt",  dv_cnt - dv_base,    32'd2);
        check_eq("t5_first",   {24'd0, dv_log[dv_base]},     32'h055);
        check_eq("t5_second",  {24'd0, dv_log[dv_base + 1]}, 32'h0FF);
        check_eq("t5_pdata",   {24'd0, p_data},     32'h0FF);

        // 6: reset during data bit 4, then 0x81
        prescale = 6'd8;
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        check_eq("t6_pre_busy",{31'd0, busy},       32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; rx_in = 1'b1;
        check_eq("t6_busy",    {31'd0, busy},       32'd0);
        check_eq("t6_pdata",   {24'd0, p_data},     32'd0);
        check_eq("t6_edge",    {26'd0, edge_cnt},   32'd0);
        idle(4);
        dv_base = dv_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(12);
        check_eq("t6_dv_cnt",  dv_cnt - dv_base,    32'd1);
        check_eq("t6_pd_81",   {24'd0, p_data},     32'h081);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
